// File: rtl/pp_bridge_pkg.sv
// Shared types, default parameters and helpers for the ping-pong bridge.
package pp_bridge_pkg;

    // Lifecycle of one tile buffer.
    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_t;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_DATA_W = 64;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_REP_W  = 4;

    // Widest replay-count field rep_norm can handle.
    localparam int REP_W_MAX  = 16;

    // A replay count of zero means "read once"; every other value passes through.
    function automatic logic [REP_W_MAX-1:0] rep_norm(input logic [REP_W_MAX-1:0] rep);
        return (rep == '0) ? REP_W_MAX'(1) : rep;
    endfunction

endpackage

// File: rtl/pp_bank.sv
// One tile buffer: flop storage, bank state and the replay count latched with word 0.
module pp_bank
    import pp_bridge_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int REP_W  = DEF_REP_W,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    input  logic                           wr_en,
    input  logic [IDX_W-1:0]               wr_idx,
    input  logic [NUM_CH-1:0][DATA_W-1:0]  wr_data,
    input  logic [REP_W-1:0]               wr_rep,
    input  logic                           rd_en,
    input  logic                           rd_release,
    input  logic [IDX_W-1:0]               rd_idx,
    output logic [NUM_CH-1:0][DATA_W-1:0]  rd_data,
    output bank_state_t                    state,
    output logic [REP_W-1:0]               rep
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    logic [NUM_CH-1:0][DATA_W-1:0] mem [DEPTH];

    // Bank state and latched replay count; a write and a read never target the same bank.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BANK_EMPTY;
            rep   <= '0;
        end else if (clear) begin
            state <= BANK_EMPTY;
            rep   <= '0;
        end else if (wr_en) begin
            if (wr_idx == '0) begin
                rep <= wr_rep;
            end
            state <= (wr_idx == LAST_IDX) ? BANK_FULL : BANK_FILLING;
        end else if (rd_en) begin
            state <= rd_release ? BANK_EMPTY : BANK_DRAINING;
        end
    end

    // Tile storage write port.
    // NOTE: storage is not reset; a bank's contents are only visible once its state says FULL.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/pp_bridge_multi.sv
// Multi-channel ping-pong bridge: two tile banks, write/read pointers and replay tracking.
module pp_bridge_multi
    import pp_bridge_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int REP_W  = DEF_REP_W
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_CH-1:0][DATA_W-1:0]  in_data,
    input  logic [REP_W-1:0]               rep_cnt,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_CH-1:0][DATA_W-1:0]  out_data,
    output logic                           out_first,
    output logic                           out_last,
    output logic                           out_final,
    output logic [1:0]                     bank_full
);

    localparam int               IDX_W    = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    // Pointer state
    logic             wr_bank;
    logic [IDX_W-1:0] wr_idx;
    logic             rd_bank;
    logic [IDX_W-1:0] rd_idx;
    // Passes still to read on rd_bank; 0 means "not yet loaded from the bank".
    logic [REP_W-1:0] rep_left;

    // Bank interface
    bank_state_t                   bank_state   [2];
    logic [REP_W-1:0]              bank_rep     [2];
    logic [NUM_CH-1:0][DATA_W-1:0] bank_rd_data [2];
    logic [1:0]                    bank_wr;
    logic [1:0]                    bank_rd;

    // Decoded control
    logic             wr_fire;
    logic             rd_fire;
    logic             rd_wrap;
    logic             rd_release;
    logic [REP_W-1:0] rep_eff;
    logic [REP_W-1:0] rep_in;

    // Handshake decode, replay bookkeeping and status outputs.
    // NOTE: every signal gets a value on every path through this block, so no latch is inferred.
    always_comb begin
        in_ready   = (bank_state[wr_bank] == BANK_EMPTY) || (bank_state[wr_bank] == BANK_FILLING);
        out_valid  = (bank_state[rd_bank] == BANK_FULL)  || (bank_state[rd_bank] == BANK_DRAINING);
        wr_fire    = in_valid  && in_ready  && !clear;
        rd_fire    = out_valid && out_ready && !clear;
        rep_eff    = (rep_left == '0) ? bank_rep[rd_bank] : rep_left;
        rep_in     = REP_W'(rep_norm(REP_W_MAX'(rep_cnt)));
        rd_wrap    = rd_fire && (rd_idx == LAST_IDX);
        rd_release = rd_wrap && (rep_eff == REP_W'(1));
        bank_wr    = {wr_fire && wr_bank, wr_fire && !wr_bank};
        bank_rd    = {rd_fire && rd_bank, rd_fire && !rd_bank};
        out_data   = bank_rd_data[rd_bank];
        out_first  = out_valid && (rd_idx == '0);
        out_last   = out_valid && (rd_idx == LAST_IDX);
        out_final  = out_last && (rep_eff == REP_W'(1));
        bank_full  = '0;
        for (int i = 0; i < 2; i++) begin
            bank_full[i] = (bank_state[i] == BANK_FULL) || (bank_state[i] == BANK_DRAINING);
        end
    end

    // Write pointer: walk the tile, then hand the next tile to the other bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank <= 1'b0;
            wr_idx  <= '0;
        end else if (clear) begin
            wr_bank <= 1'b0;
            wr_idx  <= '0;
        end else if (wr_fire) begin
            if (wr_idx == LAST_IDX) begin
                wr_idx  <= '0;
                wr_bank <= ~wr_bank;
            end else begin
                wr_idx <= wr_idx + IDX_W'(1);
            end
        end
    end

    // Read pointer: walk the tile, count passes, move on once the last pass is read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_bank  <= 1'b0;
            rd_idx   <= '0;
            rep_left <= '0;
        end else if (clear) begin
            rd_bank  <= 1'b0;
            rd_idx   <= '0;
            rep_left <= '0;
        end else if (rd_fire) begin
            if (rd_wrap) begin
                rd_idx   <= '0;
                rep_left <= rep_eff - REP_W'(1);
                if (rd_release) begin
                    rd_bank <= ~rd_bank;
                end
            end else begin
                rd_idx   <= rd_idx + IDX_W'(1);
                rep_left <= rep_eff;
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        pp_bank #(
            .NUM_CH (NUM_CH),
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .REP_W  (REP_W)
        ) u_bank (
            .clk        (clk),
            .rst_n      (rst_n),
            .clear      (clear),
            .wr_en      (bank_wr[g]),
            .wr_idx     (wr_idx),
            .wr_data    (in_data),
            .wr_rep     (rep_in),
            .rd_en      (bank_rd[g]),
            .rd_release (rd_release),
            .rd_idx     (rd_idx),
            .rd_data    (bank_rd_data[g]),
            .state      (bank_state[g]),
            .rep        (bank_rep[g])
        );
    end

endmodule

// File: tb/tb_pp_bridge_multi.sv
// Randomised bench for pp_bridge_multi against a tile-queue reference model.
module tb_pp_bridge_multi;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 16;
    localparam int REP_W  = 4;

    typedef logic [NUM_CH-1:0][DATA_W-1:0] word_t;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    word_t      in_data;
    logic [REP_W-1:0] rep_cnt;
    logic       out_valid;
    logic       out_ready;
    word_t      out_data;
    logic       out_first;
    logic       out_last;
    logic       out_final;
    logic [1:0] bank_full;

    pp_bridge_multi #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .REP_W  (REP_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .rep_cnt   (rep_cnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_first (out_first),
        .out_last  (out_last),
        .out_final (out_final),
        .bank_full (bank_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: tiles in flight, at the level of whole tiles and passes.
    word_t part_q[$];     // words of the tile being written
    int    part_rep;
    word_t done_q[$];     // words of complete tiles, tile after tile
    int    rep_q[$];      // pass count per complete tile
    int    bank_q[$];     // bank holding each complete tile
    int    next_bank;
    int    rd_pos;
    int    rd_pass;

    // Producer and statistics
    word_t cur_word;
    int    tile_rep_sel;
    bit    rand_rep;
    int    cyc;
    int    n_accept, n_reads, n_first, n_final, final_at;
    int    tile_start_cycle, rise_cycle, release_cycle, last_accept_cycle;
    int    exp_read_total;
    logic  prev_ov;

    function automatic word_t rand_word();
        word_t w;
        for (int c = 0; c < NUM_CH; c++) begin
            w[c] = {$urandom, $urandom};
        end
        return w;
    endfunction

    task automatic model_reset();
        part_q.delete();
        done_q.delete();
        rep_q.delete();
        bank_q.delete();
        next_bank = 0;
        rd_pos    = 0;
        rd_pass   = 0;
        prev_ov   = 1'b0;
    endtask

    // One clock cycle: drive at the falling edge, compare, then advance the model.
    task automatic step(input logic iv, input logic ordy, input logic clr);
        logic       exp_ready, exp_valid, lst, fin;
        logic [1:0] exp_full;
        @(negedge clk);
        in_valid  = iv;
        out_ready = ordy;
        clear     = clr;
        in_data   = cur_word;
        rep_cnt   = (part_q.size() == 0) ? REP_W'(tile_rep_sel) : REP_W'($urandom);
        #1;
        cyc++;
        exp_ready = (rep_q.size() < 2);
        exp_valid = (rep_q.size() > 0);
        exp_full  = '0;
        foreach (bank_q[i]) exp_full[bank_q[i]] = 1'b1;
        check("in_ready", in_ready, exp_ready);
        check("out_valid", out_valid, exp_valid);
        check("bank_full", bank_full, exp_full);
        lst = 1'b0;
        fin = 1'b0;
        if (exp_valid) begin
            lst = (rd_pos == DEPTH - 1);
            fin = lst && (rd_pass == rep_q[0] - 1);
            check("out_word", {out_data, out_first, out_last, out_final},
                  {done_q[rd_pos], rd_pos == 0, lst, fin});
        end else begin
            check("idle_flags", {out_first, out_last, out_final}, 3'b000);
        end
        if (out_valid && !prev_ov) rise_cycle = cyc;
        prev_ov = out_valid;
        if (clr) begin
            model_reset();
        end else begin
            if (iv && exp_ready) begin
                if (part_q.size() == 0) begin
                    part_rep         = (tile_rep_sel == 0) ? 1 : tile_rep_sel;
                    tile_start_cycle = cyc;
                end
                part_q.push_back(cur_word);
                cur_word          = rand_word();
                last_accept_cycle = cyc;
                n_accept++;
                if (part_q.size() == DEPTH) begin
                    foreach (part_q[i]) done_q.push_back(part_q[i]);
                    rep_q.push_back(part_rep);
                    bank_q.push_back(next_bank);
                    exp_read_total += part_rep * DEPTH;
                    next_bank ^= 1;
                    part_q.delete();
                    if (rand_rep) tile_rep_sel = $urandom_range(0, 5);
                end
            end
            if (exp_valid && ordy) begin
                n_reads++;
                if (rd_pos == 0) n_first++;
                if (fin) begin
                    n_final++;
                    final_at      = n_reads;
                    release_cycle = cyc;
                end
                rd_pos++;
                if (rd_pos == DEPTH) begin
                    rd_pos = 0;
                    rd_pass++;
                    if (rd_pass == rep_q[0]) begin
                        rd_pass = 0;
                        void'(rep_q.pop_front());
                        void'(bank_q.pop_front());
                        for (int i = 0; i < DEPTH; i++) void'(done_q.pop_front());
                    end
                end
            end
        end
    endtask

    // Finish any partial tile, then read everything out.
    task automatic drain();
        int guard = 0;
        while ((part_q.size() != 0 || rep_q.size() != 0) && guard < 5000) begin
            step(part_q.size() != 0, 1'b1, 1'b0);
            guard++;
        end
        check("drain_timeout", guard < 5000, 1'b1);
    endtask

    // Write one tile back-to-back with the consumer always ready, and read it out.
    task automatic run_tile(input int rep, input int exp_reads);
        int a0, r0, f0, n0, guard;
        a0 = n_accept; r0 = n_reads; f0 = n_first; n0 = n_final;
        tile_rep_sel = rep;
        guard = 0;
        while ((n_accept - a0 < DEPTH || rep_q.size() != 0) && guard < 500) begin
            step(n_accept - a0 < DEPTH, 1'b1, 1'b0);
            guard++;
        end
        check("tile_timeout", guard < 500, 1'b1);
        check("latency", rise_cycle - tile_start_cycle, DEPTH);
        check("reads", n_reads - r0, exp_reads);
        check("firsts", n_first - f0, exp_reads / DEPTH);
        check("finals", n_final - n0, 1);
        check("final_pos", final_at - r0, exp_reads);
        step(1'b0, 1'b1, 1'b0);
        check("empty_after", {in_ready, out_valid, bank_full}, 4'b1000);
    endtask

    initial begin
        int a0, r0, guard;
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; rep_cnt = '0;
        cyc = 0; n_accept = 0; n_reads = 0; n_first = 0; n_final = 0; final_at = 0;
        tile_start_cycle = 0; rise_cycle = 0; release_cycle = 0; last_accept_cycle = 0;
        exp_read_total = 0; rand_rep = 1'b0; tile_rep_sel = 1;
        cur_word = rand_word();
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_outputs", {out_valid, out_first, out_last, out_final, bank_full}, 6'b0);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);

        // Single tile, one pass, then three passes, then rep_cnt=0.
        run_tile(1, DEPTH);
        run_tile(3, 3 * DEPTH);
        run_tile(0, DEPTH);

        // Producer runs ahead of a stalled consumer.
        tile_rep_sel = 1;
        a0 = n_accept;
        repeat (40) step(1'b1, 1'b0, 1'b0);
        check("stall_accepts", n_accept - a0, 2 * DEPTH);
        check("stall_ready", in_ready, 1'b0);
        check("stall_bank_full", bank_full, 2'b11);
        guard = 0;
        while (n_accept - a0 < 2 * DEPTH + 1 && guard < 200) begin
            step(1'b1, 1'b1, 1'b0);
            guard++;
        end
        check("bubble", last_accept_cycle - release_cycle, 1);
        drain();

        // Random handshakes over 20 tiles with random replay counts.
        rand_rep = 1'b1;
        tile_rep_sel = $urandom_range(0, 5);
        a0 = n_accept;
        r0 = n_reads;
        exp_read_total = 0;
        guard = 0;
        while (n_accept - a0 < 20 * DEPTH && guard < 20000) begin
            step(1'(($urandom & 1)), 1'(($urandom & 1)), 1'b0);
            guard++;
        end
        drain();
        check("random_tiles", n_accept - a0, 20 * DEPTH);
        check("random_reads", n_reads - r0, exp_read_total);
        rand_rep = 1'b0;

        // Flush on word 7 of the second tile.
        tile_rep_sel = 1;
        a0 = n_accept;
        guard = 0;
        while (n_accept - a0 < DEPTH + 7 && guard < 200) begin
            step(1'b1, 1'b0, 1'b0);
            guard++;
        end
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check("clear_state", {in_ready, out_valid, out_first, out_last, out_final, bank_full}, 7'b1000000);
        run_tile(1, DEPTH);

        // Asynchronous reset in the middle of the second pass of a tile.
        tile_rep_sel = 2;
        a0 = n_accept;
        r0 = n_reads;
        guard = 0;
        while (n_reads - r0 < DEPTH + 4 && guard < 200) begin
            step(n_accept - a0 < DEPTH, 1'b1, 1'b0);
            guard++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        check("areset_state", {out_valid, out_first, out_last, out_final, bank_full}, 6'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        check("areset_in_ready", in_ready, 1'b1);
        run_tile(2, 2 * DEPTH);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
